reg_xfer_unit: RTL

//  Parametrised register file with one internal transfer bus. It executes register-to-register

---
 rtl/reg_xfer_unit.sv | 131 +++++++++++++
 1 files changed

// File: rtl/reg_xfer_unit.sv
// Register file with a single internal transfer bus executing MOVE, LOAD, SWAP and READ
// one operation at a time under a valid/ready handshake.
module reg_xfer_unit #(
   parameter  int WIDTH = 16,
   parameter  int NREGS = 4,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   op_valid,
   output logic                   op_ready,
   input  logic [1:0]             op,
   input  logic [AW-1:0]          src,
   input  logic [AW-1:0]          dest,
   input  logic [WIDTH-1:0]       data_in,
   output logic [WIDTH-1:0]       data_out,
   output logic                   out_valid,
   output logic                   done,
   output logic                   err,
   output logic [NREGS*WIDTH-1:0] regs_flat
);

   localparam logic [1:0] OP_MOVE = 2'b00;
   localparam logic [1:0] OP_LOAD = 2'b01;
   localparam logic [1:0] OP_SWAP = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   typedef enum logic [1:0] {IDLE, EXEC, SWAP2} state_t;

   state_t           state, state_nx;
   logic [1:0]       op_q;
   logic [AW-1:0]    src_q, dest_q;
   logic [WIDTH-1:0] regs [NREGS];
   logic [WIDTH-1:0] bus, tmp;
   logic             accept, bad;
   logic             done_nx, err_nx, ov_nx;
   logic             wr_dest, wr_src, ld_out;

   // Index width can exceed the register count when NREGS is not a power of two.
   function automatic logic idx_ok(input logic [AW-1:0] idx);
      return int'(idx) < NREGS;
   endfunction

   assign op_ready = (state == IDLE) && !rst;
   assign accept   = op_valid && op_ready;
   assign bad      = ((op_q != OP_LOAD) && !idx_ok(src_q)) ||
                     ((op_q != OP_READ) && !idx_ok(dest_q));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      done_nx  = 1'b0;
      err_nx   = 1'b0;
      ov_nx    = 1'b0;
      wr_dest  = 1'b0;
      wr_src   = 1'b0;
      ld_out   = 1'b0;
      case (state)
         IDLE: begin
            if (op_valid) state_nx = EXEC;
         end
         EXEC: begin
            case (op_q)
               OP_SWAP: begin
                  wr_dest  = !bad;
                  state_nx = SWAP2;
               end
               OP_READ: begin
                  ld_out   = !bad;
                  ov_nx    = !bad;
                  done_nx  = 1'b1;
                  err_nx   = bad;
                  state_nx = IDLE;
               end
               default: begin
                  wr_dest  = !bad;
                  done_nx  = 1'b1;
                  err_nx   = bad;
                  state_nx = IDLE;
               end
            endcase
         end
         SWAP2: begin
            wr_src   = !bad;
            done_nx  = 1'b1;
            err_nx   = bad;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         bus       <= '0;
         tmp       <= '0;
         data_out  <= '0;
         op_q      <= OP_MOVE;
         src_q     <= '0;
         dest_q    <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         done      <= done_nx;
         err       <= err_nx;
         out_valid <= ov_nx;
         // tmp captures the old destination so SWAP can restore it into src one edge later.
         if (accept) begin
            op_q   <= op;
            src_q  <= src;
            dest_q <= dest;
            bus    <= (op == OP_LOAD) ? data_in : (idx_ok(src) ? regs[src] : '0);
            tmp    <= idx_ok(dest) ? regs[dest] : '0;
         end
         if (wr_dest) regs[dest_q] <= bus;
         if (wr_src)  regs[src_q]  <= tmp;
         if (ld_out)  data_out     <= bus;
      end
   end

   for (genvar i = 0; i < NREGS; i++) begin : g_flat
      assign regs_flat[i*WIDTH +: WIDTH] = regs[i];
   end

endmodule
